// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the front-end hazard sequencer and its environment.
// Hazard/redirect inputs flow towards the sequencer; buffer enables, bubble
// controls, split indication and the stall counter flow back out.
//   master : environment side (drives decode/issue/redirect info)
//   slave  : sequencer side (drives buffer controls and stall counter)
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [1:0]       dec_valid_i;
  logic [4:0]       dec0_rd_i;
  logic [4:0]       dec1_rd_i;
  logic [4:0]       dec0_rs1_i;
  logic [4:0]       dec0_rs2_i;
  logic [4:0]       dec1_rs1_i;
  logic [4:0]       dec1_rs2_i;
  logic [1:0]       dec_wr_i;
  logic [3:0]       dec_rd_use_i;
  logic [1:0]       dec_mem_i;
  logic [1:0]       iss_load_i;
  logic [4:0]       iss0_rd_i;
  logic [4:0]       iss1_rd_i;
  logic             flush_i;
  logic             imem_stall_i;
  logic             fetch_we_o;
  logic [1:0]       dec_we_o;
  logic [1:0]       dec_sr_o;
  logic [1:0]       issue_we_o;
  logic [1:0]       issue_sr_o;
  logic             split_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output dec_valid_i, dec0_rd_i, dec1_rd_i, dec0_rs1_i, dec0_rs2_i,
           dec1_rs1_i, dec1_rs2_i, dec_wr_i, dec_rd_use_i, dec_mem_i,
           iss_load_i, iss0_rd_i, iss1_rd_i, flush_i, imem_stall_i,
    input  fetch_we_o, dec_we_o, dec_sr_o, issue_we_o, issue_sr_o,
           split_o, stall_cnt_o
  );

  modport slave (
    input  dec_valid_i, dec0_rd_i, dec1_rd_i, dec0_rs1_i, dec0_rs2_i,
           dec1_rs1_i, dec1_rs2_i, dec_wr_i, dec_rd_use_i, dec_mem_i,
           iss_load_i, iss0_rd_i, iss1_rd_i, flush_i, imem_stall_i,
    output fetch_we_o, dec_we_o, dec_sr_o, issue_we_o, issue_sr_o,
           split_o, stall_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the dual-issue front end. Produces the fetch, decode
// and issue buffer write-enables and bubble (sync-reset) controls from
// load-use, intra-pair, memory-port, redirect and imem-wait conditions.
// Ports:
//   clock_i   : clock
//   reset_n_i : asynchronous active-low reset
//   bus       : slave side of pipeline_hazard_ctrl_if (hazard info in,
//               buffer controls, split flag and stall counter out)
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {INIT, RUN, SPLIT, FLUSH} state_t;

  state_t           state, state_nx;
  logic [FC_W-1:0]  fcnt, fcnt_nx;
  logic [CNT_W-1:0] stall_cnt;

  logic       fetch_we;
  logic [1:0] dec_we, dec_sr, issue_we, issue_sr;

  logic [3:0][4:0] src;
  logic [3:0]      src_ld;
  logic            lu, ph;

  // Slot1's destination and write flag only matter to the following pair.
  logic unused;
  assign unused = ^{bus.dec_wr_i[1], bus.dec1_rd_i};

  // x0 is never a real dependency.
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != '0);
  endfunction

  assign src = {bus.dec1_rs2_i, bus.dec1_rs1_i, bus.dec0_rs2_i, bus.dec0_rs1_i};

  always_comb begin
    src_ld = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      src_ld[i] = bus.dec_rd_use_i[i] &&
                  ((bus.iss_load_i[0] && hit(src[i], bus.iss0_rd_i)) ||
                   (bus.iss_load_i[1] && hit(src[i], bus.iss1_rd_i)));
    end
  end

  // While split, slot0 has already issued; only the held slot1 can stall.
  assign lu = (state == SPLIT) ? (|src_ld[3:2]) : (|src_ld);

  assign ph = (&bus.dec_valid_i) &&
              ((bus.dec_wr_i[0] &&
                ((bus.dec_rd_use_i[2] && hit(bus.dec0_rd_i, bus.dec1_rs1_i)) ||
                 (bus.dec_rd_use_i[3] && hit(bus.dec0_rd_i, bus.dec1_rs2_i)))) ||
               (bus.dec_mem_i == 2'b11));

  // State register
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= INIT;
      fcnt  <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    case (state)
      INIT: state_nx = RUN;
      RUN, SPLIT, FLUSH: begin
        if (bus.flush_i) begin
          if (FLUSH_CYCLES > 1) begin
            state_nx = FLUSH;
            fcnt_nx  = FC_LOAD;
          end else begin
            state_nx = RUN;
          end
        end else if (state == FLUSH) begin
          fcnt_nx = fcnt - 1'b1;
          if (fcnt == FC_W'(1)) state_nx = RUN;
        end else if (state == SPLIT) begin
          if (!lu) state_nx = RUN;
        end else if (!bus.imem_stall_i && !lu && ph) begin
          state_nx = SPLIT;
        end
      end
      default: state_nx = INIT;
    endcase
  end

  // Output logic; bubbled slots always drive we=0.
  always_comb begin
    fetch_we = 1'b0;
    dec_we   = 2'b00;
    dec_sr   = 2'b11;
    issue_we = 2'b00;
    issue_sr = 2'b11;
    if (state != INIT && (bus.flush_i || state == FLUSH)) begin
      fetch_we = 1'b1;
    end else if (state == RUN) begin
      dec_sr = 2'b00;
      if (bus.imem_stall_i || lu) begin
        issue_sr = 2'b11;
      end else if (ph) begin
        issue_we = 2'b01;
        issue_sr = 2'b10;
      end else begin
        fetch_we = 1'b1;
        dec_we   = 2'b11;
        issue_we = bus.dec_valid_i;
        issue_sr = ~bus.dec_valid_i;
      end
    end else if (state == SPLIT) begin
      dec_sr = 2'b00;
      if (!lu) begin
        fetch_we = 1'b1;
        dec_we   = 2'b11;
        issue_we = {bus.dec_valid_i[1], 1'b0};
        issue_sr = {~bus.dec_valid_i[1], 1'b1};
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt <= '0;
    end else if (!fetch_we && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.fetch_we_o  = fetch_we;
  assign bus.dec_we_o    = dec_we;
  assign bus.dec_sr_o    = dec_sr;
  assign bus.issue_we_o  = issue_we;
  assign bus.issue_sr_o  = issue_sr;
  assign bus.split_o     = (state == SPLIT);
  assign bus.stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  logic clk;
  logic rst_n;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) bus32 ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut32 (
    .clock_i(clk), .reset_n_i(rst_n), .bus(bus32)
  );
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
    .clock_i(clk), .reset_n_i(rst_n), .bus(bus4)
  );

  // Narrow-counter instance sees exactly the same stimulus.
  assign bus4.dec_valid_i  = bus32.dec_valid_i;
  assign bus4.dec0_rd_i    = bus32.dec0_rd_i;
  assign bus4.dec1_rd_i    = bus32.dec1_rd_i;
  assign bus4.dec0_rs1_i   = bus32.dec0_rs1_i;
  assign bus4.dec0_rs2_i   = bus32.dec0_rs2_i;
  assign bus4.dec1_rs1_i   = bus32.dec1_rs1_i;
  assign bus4.dec1_rs2_i   = bus32.dec1_rs2_i;
  assign bus4.dec_wr_i     = bus32.dec_wr_i;
  assign bus4.dec_rd_use_i = bus32.dec_rd_use_i;
  assign bus4.dec_mem_i    = bus32.dec_mem_i;
  assign bus4.iss_load_i   = bus32.iss_load_i;
  assign bus4.iss0_rd_i    = bus32.iss0_rd_i;
  assign bus4.iss1_rd_i    = bus32.iss1_rd_i;
  assign bus4.flush_i      = bus32.flush_i;
  assign bus4.imem_stall_i = bus32.imem_stall_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  rd0, rd1, s0r1, s0r2, s1r1, s1r2;
    logic [1:0]  wr;
    logic [3:0]  used;
    logic [1:0]  mem, ld;
    logic [4:0]  ird0, ird1;
    logic        flush, imem;
    logic        fwe;
    logic [1:0]  dwe, dsr, iwe, isr;
    logic        split;
    int unsigned cnt;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t base();
    vec_t v;
    v.valid = 2'b11; v.rd0 = 5'd1; v.rd1 = 5'd2;
    v.s0r1 = 5'd3; v.s0r2 = 5'd4; v.s1r1 = 5'd5; v.s1r2 = 5'd6;
    v.wr = 2'b11; v.used = 4'b1111; v.mem = 2'b00; v.ld = 2'b00;
    v.ird0 = 5'd10; v.ird1 = 5'd11; v.flush = 1'b0; v.imem = 1'b0;
    v.fwe = 1'b0; v.dwe = 2'b00; v.dsr = 2'b00; v.iwe = 2'b00; v.isr = 2'b00;
    v.split = 1'b0; v.cnt = 0;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t v, input logic fwe,
                              input logic [1:0] dwe, input logic [1:0] dsr,
                              input logic [1:0] iwe, input logic [1:0] isr,
                              input logic split, input int unsigned cnt);
    vec_t r = v;
    r.fwe = fwe; r.dwe = dwe; r.dsr = dsr; r.iwe = iwe; r.isr = isr;
    r.split = split; r.cnt = cnt;
    return r;
  endfunction

  // Common expected responses
  function automatic vec_t nrm(input vec_t v, input int unsigned c);
    return ex(v, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 1'b0, c);
  endfunction
  function automatic vec_t stl(input vec_t v, input logic s, input int unsigned c);
    return ex(v, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, s, c);
  endfunction
  function automatic vec_t sin(input vec_t v, input int unsigned c);
    return ex(v, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 1'b0, c);
  endfunction
  function automatic vec_t rel(input vec_t v, input int unsigned c);
    return ex(v, 1'b1, 2'b11, 2'b00, 2'b10, 2'b01, 1'b1, c);
  endfunction
  function automatic vec_t fl(input vec_t v, input logic s, input int unsigned c);
    return ex(v, 1'b1, 2'b00, 2'b11, 2'b00, 2'b11, s, c);
  endfunction

  task automatic drive(input vec_t v);
    bus32.dec_valid_i  = v.valid;
    bus32.dec0_rd_i    = v.rd0;
    bus32.dec1_rd_i    = v.rd1;
    bus32.dec0_rs1_i   = v.s0r1;
    bus32.dec0_rs2_i   = v.s0r2;
    bus32.dec1_rs1_i   = v.s1r1;
    bus32.dec1_rs2_i   = v.s1r2;
    bus32.dec_wr_i     = v.wr;
    bus32.dec_rd_use_i = v.used;
    bus32.dec_mem_i    = v.mem;
    bus32.iss_load_i   = v.ld;
    bus32.iss0_rd_i    = v.ird0;
    bus32.iss1_rd_i    = v.ird1;
    bus32.flush_i      = v.flush;
    bus32.imem_stall_i = v.imem;
  endtask

  function automatic logic [9:0] outs();
    return {bus32.fetch_we_o, bus32.dec_we_o, bus32.dec_sr_o,
            bus32.issue_we_o, bus32.issue_sr_o, bus32.split_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic [9:0] want;
    want = {v.fwe, v.dwe, v.dsr, v.iwe, v.isr, v.split};
    checks++;
    if (outs() !== want || bus32.stall_cnt_o !== 32'(v.cnt)) begin
      errors++;
      $display("FAIL vec%0d: got fwe_dwe_dsr_iwe_isr_split=%b cnt=%0d want %b cnt=%0d",
               idx, outs(), bus32.stall_cnt_o, want, v.cnt);
    end
  endtask

  initial begin
    vec_t t;

    // Vector table: one entry per cycle, outputs sampled before the edge.
    t = base();                                         vq.push_back(ex(t, 1'b0, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, 0)); // INIT
    t = base();                                         vq.push_back(nrm(t, 1));
    t = base(); t.valid = 2'b01;                        vq.push_back(ex(t, 1'b1, 2'b11, 2'b00, 2'b01, 2'b10, 1'b0, 1));
    t = base(); t.rd0 = 5'd5;                           vq.push_back(sin(t, 1));       // rd0 feeds slot1 rs1
    t = base(); t.rd0 = 5'd5;                           vq.push_back(rel(t, 2));
    t = base();                                         vq.push_back(nrm(t, 2));
    t = base(); t.ld = 2'b10; t.ird1 = 5'd7; t.s0r1 = 5'd7; vq.push_back(stl(t, 1'b0, 2)); // load-use
    t = base();                                         vq.push_back(nrm(t, 3));
    t = base(); t.ld = 2'b10; t.ird1 = 5'd0; t.s0r1 = 5'd0; vq.push_back(nrm(t, 3));      // x0
    t = base(); t.ld = 2'b01; t.ird0 = 5'd4; t.used = 4'b1101; vq.push_back(nrm(t, 3));   // unused src
    t = base(); t.mem = 2'b11;                          vq.push_back(sin(t, 3));       // two mem ops
    t = base(); t.mem = 2'b11; t.ld = 2'b01; t.ird0 = 5'd3; vq.push_back(rel(t, 4));      // slot0 LU ignored in SPLIT
    t = base(); t.mem = 2'b11;                          vq.push_back(sin(t, 4));
    t = base(); t.mem = 2'b11; t.ld = 2'b01; t.ird0 = 5'd5; vq.push_back(stl(t, 1'b1, 5)); // slot1 LU in SPLIT
    t = base(); t.mem = 2'b11; t.imem = 1'b1;           vq.push_back(rel(t, 6));       // imem ignored in SPLIT
    t = base(); t.mem = 2'b11;                          vq.push_back(sin(t, 6));
    t = base(); t.mem = 2'b11; t.flush = 1'b1;          vq.push_back(fl(t, 1'b1, 7));  // flush in SPLIT
    t = base();                                         vq.push_back(fl(t, 1'b0, 7));  // FLUSH
    t = base(); t.valid = 2'b10;                        vq.push_back(ex(t, 1'b1, 2'b11, 2'b00, 2'b10, 2'b01, 1'b0, 7));
    t = base(); t.flush = 1'b1; t.imem = 1'b1;          vq.push_back(fl(t, 1'b0, 7));  // flush beats imem
    t = base(); t.flush = 1'b1;                         vq.push_back(fl(t, 1'b0, 7));  // reload in FLUSH
    t = base();                                         vq.push_back(fl(t, 1'b0, 7));
    t = base(); t.imem = 1'b1;                          vq.push_back(stl(t, 1'b0, 7));
    t = base(); t.imem = 1'b1;                          vq.push_back(stl(t, 1'b0, 8));
    t = base(); t.imem = 1'b1;                          vq.push_back(stl(t, 1'b0, 9));
    t = base();                                         vq.push_back(nrm(t, 10));
    t = base(); t.rd0 = 5'd5; t.ld = 2'b10; t.ird1 = 5'd6; vq.push_back(stl(t, 1'b0, 10)); // LU beats PH
    t = base(); t.rd0 = 5'd5;                           vq.push_back(sin(t, 11));
    t = base(); t.rd0 = 5'd5;                           vq.push_back(rel(t, 12));
    t = base(); t.rd0 = 5'd5; t.wr = 2'b10;             vq.push_back(nrm(t, 12));      // slot0 not writing
    t = base(); t.rd0 = 5'd0; t.s1r1 = 5'd0;            vq.push_back(nrm(t, 12));      // x0 pair
    t = base(); t.rd0 = 5'd6; t.used = 4'b0111;         vq.push_back(nrm(t, 12));      // rs2 unused
    t = base(); t.valid = 2'b01; t.mem = 2'b11;         vq.push_back(ex(t, 1'b1, 2'b11, 2'b00, 2'b01, 2'b10, 1'b0, 12));

    // Reset state
    rst_n = 1'b0;
    drive(base());
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'(10'b0_00_11_00_11_0));
    chk("reset_cnt", bus32.stall_cnt_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(negedge clk);
      check_vec(i, vq[i]);
      @(posedge clk); #1;
    end

    // Asynchronous reset while split
    t = base(); t.mem = 2'b11;
    drive(t);
    @(posedge clk); #1;
    drive(base());
    #2;
    chk("split_before_reset", 32'(bus32.split_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs()), 32'(10'b0_00_11_00_11_0));
    chk("async_reset_cnt32", bus32.stall_cnt_o, 32'd0);
    chk("async_reset_cnt4", 32'(bus4.stall_cnt_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_after_reset", 32'(outs()), 32'(10'b0_00_11_00_11_0));
    chk("cnt_held_in_reset", bus32.stall_cnt_o, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("run_after_reset", 32'(outs()), 32'(10'b1_11_00_11_00_0));
    chk("cnt_after_init", bus32.stall_cnt_o, 32'd1);

    // Long imem wait: 32-bit counter keeps counting, 4-bit saturates.
    bus32.imem_stall_i = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    chk("cnt32_14", bus32.stall_cnt_o, 32'd14);
    chk("cnt4_14", 32'(bus4.stall_cnt_o), 32'd14);
    repeat (7) @(posedge clk);
    #1;
    chk("cnt32_21", bus32.stall_cnt_o, 32'd21);
    chk("cnt4_sat", 32'(bus4.stall_cnt_o), 32'd15);
    chk("cnt4_fetch_held", 32'(bus4.fetch_we_o), 32'd0);
    bus32.imem_stall_i = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
